pattern_bank: RTL and testbench
===============================

PATTERN_BANK -- requirements
Module: pattern_bank

Interface
REQ-001 Parameter: NUM_BUFS, default 8, number of pattern buffers (power of two, 2..16).
REQ-002 Parameter: BUF_BYTES, default 32, entries per buffer (power of two, 4..64).
REQ-003 Parameter: BUF_WIDTH, default 8, bits per entry.
REQ-004 Port: clk  in  1  sole clock; all state changes on rising edge.
REQ-005 Port: rst  in  1  asynchronous, active-high reset.
REQ-006 Port: ssel, sshift, sin  in  1 each  serial select, shift strobe, serial data in.
REQ-007 Port: saddr  in  clog2(NUM_BUFS)  serial target buffer.
REQ-008 Port: sout  out  1  serial data out of the addressed buffer.
REQ-009 Port: scan_done  out  1  one-cycle pulse after a full-buffer shift.
REQ-010 Port: sel_req, sel_bufp  in  1, clog2(NUM_BUFS)  active-buffer change request and target.
REQ-011 Port: sel_ack  out  1  one-cycle pulse on request acceptance.
REQ-012 Port: cur_bufp  out  clog2(NUM_BUFS)  active buffer index.
REQ-013 Port: fieldp  in  clog2(BUF_BYTES)+1  field address; MSB set means out of range.
REQ-014 Port: field_in, field_write  in  BUF_WIDTH, 1  write data and strobe into the active buffer.
REQ-015 Port: field_byte  out  BUF_WIDTH  registered read of active buffer at fieldp.
REQ-016 Port: field_err  out  1  sticky error flag; cleared only by rst.

Function
REQ-017 Each ssel&&sshift cycle, the buffer at saddr shifts one bit: sin enters entry 0 bit 0; bit BUF_WIDTH-1 of entry k moves to bit 0 of entry k+1; other buffers hold.
REQ-018 sout = bit BUF_WIDTH-1 of entry BUF_BYTES-1 of the buffer at saddr, taken combinationally from registers; forced to 0 when ssel is low.
REQ-019 A shift counter counts accepted shifts; at BUF_BYTES*BUF_WIDTH it wraps to 0 and scan_done pulses the next cycle.
REQ-020 The shift counter clears to 0 whenever ssel is low or saddr changes.
REQ-021 field_byte latency is 1 cycle: it registers active[fieldp]; same-cycle write returns the old value; a read of the same address on the next cycle returns the new value.
REQ-022 With fieldp out of range: field_byte registers 0, writes are ignored, and field_err sets if field_write is high.
REQ-023 A field_write in the same cycle as a shift on the active buffer is dropped (shift wins) and sets field_err.
REQ-024 sel_req is accepted when field_write is low; sel_ack pulses that cycle and cur_bufp takes sel_bufp on the next edge.
REQ-025 A refused sel_req has no effect; the requester holds sel_req until sel_ack.
REQ-026 The first read after a cur_bufp change returns data from the new buffer.
REQ-027 A shift and a field write on different buffers in the same cycle both take effect.

Reset
REQ-028 rst clears all buffer contents, shift counter, cur_bufp, field_byte, scan_done, sel_ack and field_err to 0.
REQ-029 rst asserted mid-shift or mid-request aborts the operation; no partial update survives.

Structure
REQ-030 pattern_bank_pkg holds the default parameters, derived index widths and the shift-length constant.
REQ-031 Sub-module pattern_store implements one buffer (shift chain, write port, read mux) and is instanced NUM_BUFS times via generate.

Verification
REQ-032 Shift 256 bits of pattern 0xA5 per byte into buffer 3 (defaults) -> scan_done pulses once; with sel_bufp=3, reads of fieldp 0..31 return 0xA5.
REQ-033 Write 0x3C at fieldp 5 and read fieldp 5 in the same cycle, then the next cycle -> old value, then 0x3C.
REQ-034 Assert sel_req with field_write high for 2 cycles, then drop field_write -> sel_ack only in the third cycle; cur_bufp changes the following cycle.
REQ-035 Apply fieldp=32 with field_write -> contents unchanged, field_byte=0, field_err=1 until rst.
REQ-036 Shift the active buffer and field_write in the same cycle -> write lost, field_err=1; then assert rst mid-shift -> all outputs 0 and sout=0.

Source files
------------

// File: rtl/pattern_bank_pkg.sv
// Shared defaults and derived sizes for the pattern bank and its per-buffer store.
package pattern_bank_pkg;
    localparam int NUM_BUFS_DEF  = 8;
    localparam int BUF_BYTES_DEF = 32;
    localparam int BUF_WIDTH_DEF = 8;
    localparam int BUF_IDX_W_DEF = $clog2(NUM_BUFS_DEF);
    localparam int ENT_IDX_W_DEF = $clog2(BUF_BYTES_DEF);

    // Number of serial shifts needed to replace a whole buffer.
    function automatic int shift_len(input int bytes, input int width);
        return bytes * width;
    endfunction

    localparam int SHIFT_LEN_DEF = shift_len(BUF_BYTES_DEF, BUF_WIDTH_DEF);
endpackage

// File: rtl/pattern_store.sv
// One pattern buffer: serial shift chain through all entries, single write port, async read mux.
module pattern_store #(
    parameter int BUF_BYTES = 32,
    parameter int BUF_WIDTH = 8,
    parameter int AW        = $clog2(BUF_BYTES)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 shift_en,
    input  logic                 sin,
    input  logic                 wr_en,
    input  logic [AW-1:0]        addr,
    input  logic [BUF_WIDTH-1:0] wr_data,
    output logic [BUF_WIDTH-1:0] rd_data,
    output logic                 sout
);
    localparam int NBITS = BUF_BYTES * BUF_WIDTH;

    logic [BUF_BYTES-1:0][BUF_WIDTH-1:0] mem;

    // Treating the packed array as one vector makes the MSB of entry k feed the LSB of entry k+1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            mem <= '0;
        else if (shift_en)
            mem <= NBITS'({mem, sin});
        else if (wr_en)
            mem[addr] <= wr_data;
    end

    assign rd_data = mem[addr];
    assign sout    = mem[BUF_BYTES-1][BUF_WIDTH-1];
endmodule

// File: rtl/pattern_bank.sv
// Bank of serially loadable pattern buffers with one selectable active buffer for field access.
module pattern_bank
    import pattern_bank_pkg::*;
#(
    parameter int NUM_BUFS  = NUM_BUFS_DEF,
    parameter int BUF_BYTES = BUF_BYTES_DEF,
    parameter int BUF_WIDTH = BUF_WIDTH_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ssel,
    input  logic                          sshift,
    input  logic                          sin,
    input  logic [$clog2(NUM_BUFS)-1:0]   saddr,
    output logic                          sout,
    output logic                          scan_done,
    input  logic                          sel_req,
    input  logic [$clog2(NUM_BUFS)-1:0]   sel_bufp,
    output logic                          sel_ack,
    output logic [$clog2(NUM_BUFS)-1:0]   cur_bufp,
    input  logic [$clog2(BUF_BYTES):0]    fieldp,
    input  logic [BUF_WIDTH-1:0]          field_in,
    input  logic                          field_write,
    output logic [BUF_WIDTH-1:0]          field_byte,
    output logic                          field_err
);
    localparam int BW   = $clog2(NUM_BUFS);
    localparam int AW   = $clog2(BUF_BYTES);
    localparam int SLEN = shift_len(BUF_BYTES, BUF_WIDTH);
    localparam int CW   = $clog2(SLEN);

    logic                                shift_acc, shift_on_active, oor, wr_ok;
    logic [AW-1:0]                       faddr;
    logic [BW-1:0]                       saddr_q;
    logic [CW-1:0]                       cnt;
    logic [NUM_BUFS-1:0][BUF_WIDTH-1:0]  rd_all;
    logic [NUM_BUFS-1:0]                 sout_all;

    assign shift_acc       = ssel && sshift;
    assign shift_on_active = shift_acc && (saddr == cur_bufp);
    assign oor             = fieldp[AW];
    assign faddr           = fieldp[AW-1:0];
    assign wr_ok           = field_write && !oor && !shift_on_active;
    assign sel_ack         = sel_req && !field_write && !rst;
    assign sout            = ssel && sout_all[saddr];

    for (genvar i = 0; i < NUM_BUFS; i++) begin : g_buf
        pattern_store #(
            .BUF_BYTES(BUF_BYTES),
            .BUF_WIDTH(BUF_WIDTH),
            .AW       (AW)
        ) u_store (
            .clk     (clk),
            .rst     (rst),
            .shift_en(shift_acc && (saddr == BW'(i))),
            .sin     (sin),
            .wr_en   (wr_ok && (cur_bufp == BW'(i))),
            .addr    (faddr),
            .wr_data (field_in),
            .rd_data (rd_all[i]),
            .sout    (sout_all[i])
        );
    end

    // Dropping ssel or retargeting saddr restarts the full-buffer count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            saddr_q   <= '0;
            scan_done <= 1'b0;
        end else begin
            saddr_q   <= saddr;
            scan_done <= 1'b0;
            if (!ssel || saddr != saddr_q) begin
                cnt <= '0;
            end else if (shift_acc) begin
                if (cnt == CW'(SLEN - 1)) begin
                    cnt       <= '0;
                    scan_done <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_bufp   <= '0;
            field_byte <= '0;
            field_err  <= 1'b0;
        end else begin
            if (sel_ack)
                cur_bufp <= sel_bufp;
            field_byte <= oor ? '0 : rd_all[cur_bufp];
            if (field_write && (oor || shift_on_active))
                field_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_pattern_bank.sv
// Directed bench for pattern_bank: serial load, field read/write, select handshake, error and reset paths.
module tb_pattern_bank;
    logic       clk = 1'b0;
    logic       rst, ssel, sshift, sin, sel_req, field_write;
    logic [2:0] saddr, sel_bufp;
    logic [5:0] fieldp;
    logic [7:0] field_in;
    logic       sout, scan_done, sel_ack, field_err;
    logic [2:0] cur_bufp;
    logic [7:0] field_byte;

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] exp_q[$];

    pattern_bank dut (
        .clk(clk), .rst(rst), .ssel(ssel), .sshift(sshift), .sin(sin), .saddr(saddr),
        .sout(sout), .scan_done(scan_done), .sel_req(sel_req), .sel_bufp(sel_bufp),
        .sel_ack(sel_ack), .cur_bufp(cur_bufp), .fieldp(fieldp), .field_in(field_in),
        .field_write(field_write), .field_byte(field_byte), .field_err(field_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected read pushed as the address is driven, popped once the registered byte appears.
    task automatic expect_rd(input string tag, input logic [7:0] e);
        exp_q.push_back(e);
        tick();
        chk(tag, field_byte, exp_q.pop_front());
    endtask

    task automatic rd(input logic [5:0] a, input logic [7:0] e);
        fieldp      = a;
        field_write = 1'b0;
        expect_rd("rd", e);
    endtask

    task automatic sel(input logic [2:0] b);
        sel_req     = 1'b1;
        sel_bufp    = b;
        field_write = 1'b0;
        #1 chk("sel_ack", sel_ack, 1);
        tick();
        sel_req = 1'b0;
        chk("cur_bufp", cur_bufp, b);
    endtask

    initial begin
        logic [7:0] pat;
        int dones;
        pat = 8'hA5;
        rst = 1'b1; ssel = 0; sshift = 0; sin = 0; saddr = 0; sel_req = 0; sel_bufp = 0;
        fieldp = 0; field_in = 0; field_write = 0;
        repeat (3) tick();
        chk("rst_field_byte", field_byte, 0);
        chk("rst_field_err", field_err, 0);
        chk("rst_cur_bufp", cur_bufp, 0);
        chk("rst_scan_done", scan_done, 0);
        chk("rst_sout", sout, 0);
        rst = 1'b0;
        tick();

        // Serial load of buffer 3, MSB of each byte first so every entry ends up 0xA5.
        ssel = 1; saddr = 3;
        tick();
        dones = 0;
        for (int s = 0; s < 256; s++) begin
            sshift = 1;
            sin    = pat[7 - (s % 8)];
            tick();
            if (s < 255 && scan_done) dones++;
        end
        chk("scan_done_early", dones, 0);
        chk("scan_done_pulse", scan_done, 1);
        chk("sout_on", sout, 1);
        sshift = 0;
        tick();
        chk("scan_done_single", scan_done, 0);
        ssel = 0;
        #1 chk("sout_ssel_low", sout, 0);

        sel(3);
        for (int a = 0; a < 32; a++) rd(6'(a), 8'hA5);

        // Same-cycle write returns old data; next read sees new data.
        fieldp = 5; field_in = 8'h3C; field_write = 1;
        expect_rd("wr_same_cycle", 8'hA5);
        field_write = 0;
        expect_rd("wr_next_cycle", 8'h3C);

        // Select request refused while field_write is high.
        sel_req = 1; sel_bufp = 0;
        fieldp = 6; field_in = 8'h11; field_write = 1;
        #1 chk("sel_refuse1", sel_ack, 0);
        tick();
        chk("cur_hold1", cur_bufp, 3);
        fieldp = 7; field_in = 8'h22;
        #1 chk("sel_refuse2", sel_ack, 0);
        tick();
        chk("cur_hold2", cur_bufp, 3);
        field_write = 0;
        #1 chk("sel_accept", sel_ack, 1);
        tick();
        sel_req = 0;
        chk("cur_switch", cur_bufp, 0);
        #1 chk("sel_ack_drop", sel_ack, 0);
        rd(0, 8'h00);

        // Shift buffer 1 while writing active buffer 0: both land.
        ssel = 1; saddr = 1; sshift = 1; sin = 1;
        fieldp = 2; field_in = 8'h77; field_write = 1;
        tick();
        ssel = 0; sshift = 0; field_write = 0;
        chk("no_err_diff_buf", field_err, 0);
        rd(2, 8'h77);
        sel(3);
        rd(6, 8'h11);
        rd(7, 8'h22);
        sel(1);
        rd(0, 8'h01);

        // Out-of-range field access.
        fieldp = 6'd32; field_in = 8'hFF; field_write = 1;
        expect_rd("oor_byte", 8'h00);
        field_write = 0;
        chk("oor_err", field_err, 1);
        rd(0, 8'h01);

        // Shift on the active buffer wins over a field write.
        ssel = 1; saddr = 1; sshift = 1; sin = 1;
        fieldp = 0; field_in = 8'h55; field_write = 1;
        tick();
        sshift = 0; field_write = 0;
        rd(0, 8'h03);
        chk("err_sticky", field_err, 1);

        // Reset asserted between edges in the middle of a shift and a select request.
        sshift = 1; sin = 1; sel_req = 1; sel_bufp = 5;
        tick(); tick();
        #2 rst = 1;
        #1;
        chk("mid_rst_field_byte", field_byte, 0);
        chk("mid_rst_field_err", field_err, 0);
        chk("mid_rst_cur_bufp", cur_bufp, 0);
        chk("mid_rst_scan_done", scan_done, 0);
        chk("mid_rst_sel_ack", sel_ack, 0);
        chk("mid_rst_sout", sout, 0);
        tick();
        rst = 0; ssel = 0; sshift = 0; sel_req = 0;
        rd(2, 8'h00);
        sel(3);
        rd(0, 8'h00);
        chk("post_rst_err", field_err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
